pipelined_cla_addsub: RTL and testbench

PIPELINED_CLA_ADDSUB -- requirements
Module: pipelined_cla_addsub

---
 rtl/pipelined_cla_pkg.sv | 11 +
 rtl/cla_segment.sv | 39 +++
 rtl/pipelined_cla_addsub.sv | 110 +++++++++++
 tb/tb_pipelined_cla_addsub.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_cla_pkg.sv
// rtl/pipelined_cla_pkg.sv - shared defaults and stage-count helper for the pipelined CLA adder/subtractor
package pipelined_cla_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int DEFAULT_SEG_W = 8;

    function automatic int calc_stages(input int width, input int seg_w);
        return width / seg_w;
    endfunction

endpackage

// File: rtl/cla_segment.sv
// rtl/cla_segment.sv - combinational carry-lookahead adder for one SEG_W-bit segment
module cla_segment #(
    parameter int SEG_W = 8
) (
    input  logic [SEG_W-1:0] a,
    input  logic [SEG_W-1:0] b,
    input  logic             cin,
    output logic [SEG_W-1:0] sum,
    output logic             cout
);

    logic [SEG_W-1:0] gen;
    logic [SEG_W-1:0] prop;
    logic [SEG_W:0]   carry;
    logic             chain;
    logic             term;

    // Every carry is its own sum of generate/propagate products, so no carry depends on another.
    always_comb begin
        gen   = a & b;
        prop  = a ^ b;
        carry = '0;
        chain = 1'b1;
        term  = 1'b0;
        for (int i = 0; i <= SEG_W; i++) begin
            term  = 1'b0;
            chain = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                term  = term | (gen[j] & chain);
                chain = chain & prop[j];
            end
            carry[i] = term | (cin & chain);
        end
    end

    assign sum  = prop ^ carry[SEG_W-1:0];
    assign cout = carry[SEG_W];

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - segment-pipelined carry-lookahead adder/subtractor with valid/ready flow control
module pipelined_cla_addsub
    import pipelined_cla_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int SEG_W = DEFAULT_SEG_W
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] add1_i,
    input  logic [WIDTH-1:0] add2_i,
    input  logic             carry_i,
    input  logic             sub_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH:0]   result_o,
    output logic             overflow_o
);

    localparam int STAGES = calc_stages(WIDTH, SEG_W);

    logic             advance;
    logic [WIDTH-1:0] b_eff;

    logic [WIDTH-1:0] src_mix   [STAGES];
    logic [WIDTH-1:0] src_b     [STAGES];
    logic             src_carry [STAGES];
    logic             src_valid [STAGES];
    logic [SEG_W-1:0] seg_sum   [STAGES];
    logic             seg_cout  [STAGES];

    // mix holds finished sum segments below the active stage and untouched A segments above it.
    logic [WIDTH-1:0] mix_d   [STAGES];
    logic [WIDTH-1:0] mix_q   [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic             carry_d [STAGES];
    logic             carry_q [STAGES];
    logic             valid_d [STAGES];
    logic             valid_q [STAGES];
    logic             overflow_d;
    logic             overflow_q;

    // Subtract mode is folded into the inverted operand and the stage-0 carry at entry.
    assign b_eff   = sub_i ? ~add2_i : add2_i;
    assign advance = !valid_q[STAGES-1] || out_ready_i;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_head
            assign src_mix[k]   = add1_i;
            assign src_b[k]     = b_eff;
            assign src_carry[k] = sub_i | carry_i;
            assign src_valid[k] = in_valid_i;
        end else begin : g_body
            assign src_mix[k]   = mix_q[k-1];
            assign src_b[k]     = b_q[k-1];
            assign src_carry[k] = carry_q[k-1];
            assign src_valid[k] = valid_q[k-1];
        end

        cla_segment #(
            .SEG_W(SEG_W)
        ) u_seg (
            .a    (src_mix[k][k*SEG_W +: SEG_W]),
            .b    (src_b[k][k*SEG_W +: SEG_W]),
            .cin  (src_carry[k]),
            .sum  (seg_sum[k]),
            .cout (seg_cout[k])
        );
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            mix_d[k]                     = src_mix[k];
            mix_d[k][k*SEG_W +: SEG_W]   = seg_sum[k];
            b_d[k]                       = src_b[k];
            carry_d[k]                   = seg_cout[k];
            valid_d[k]                   = src_valid[k];
        end
        overflow_d = (src_mix[STAGES-1][WIDTH-1] == src_b[STAGES-1][WIDTH-1])
                  && (seg_sum[STAGES-1][SEG_W-1] != src_mix[STAGES-1][WIDTH-1]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int k = 0; k < STAGES; k++) begin
                valid_q[k] <= 1'b0;
            end
            mix_q[STAGES-1]   <= '0;
            carry_q[STAGES-1] <= 1'b0;
            overflow_q        <= 1'b0;
        end else if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                mix_q[k]   <= mix_d[k];
                b_q[k]     <= b_d[k];
                carry_q[k] <= carry_d[k];
                valid_q[k] <= valid_d[k];
            end
            overflow_q <= overflow_d;
        end
    end

    assign in_ready_o  = advance;
    assign out_valid_o = valid_q[STAGES-1];
    assign result_o    = {carry_q[STAGES-1], mix_q[STAGES-1]};
    assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;

    localparam int WIDTH  = 32;
    localparam int SEG_W  = 8;
    localparam int STAGES = 4;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] add1_i;
    logic [WIDTH-1:0] add2_i;
    logic             carry_i;
    logic             sub_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH:0]   result_o;
    logic             overflow_o;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(
        .WIDTH(WIDTH),
        .SEG_W(SEG_W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .add1_i      (add1_i),
        .add2_i      (add2_i),
        .carry_i     (carry_i),
        .sub_i       (sub_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .result_o    (result_o),
        .overflow_o  (overflow_o)
    );

    int checks = 0;
    int passes = 0;
    int n_out  = 0;
    logic [WIDTH+1:0] exp_q [$];
    logic             mon_en     = 1'b0;
    logic             stall_prev = 1'b0;
    logic [WIDTH:0]   prev_res;
    logic             prev_ovf;

    // Reference: plain integer arithmetic; overflow is "signed result out of WIDTH-bit range".
    function automatic logic [WIDTH+1:0] model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic c, input logic s);
        longint unsigned ur;
        longint          sr;
        logic            ovf;
        if (s) begin
            ur = 64'(a) + 64'h1_0000_0000 - 64'(b);
            sr = longint'($signed(a)) - longint'($signed(b));
        end else begin
            ur = 64'(a) + 64'(b) + 64'(c);
            sr = longint'($signed(a)) + longint'($signed(b)) + longint'(c);
        end
        ovf = (sr > 64'sd2147483647) || (sr < -64'sd2147483648);
        return {ovf, ur[WIDTH:0]};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            if (!rst_ni) begin
                exp_q.delete();
                stall_prev = 1'b0;
            end else begin
                logic [WIDTH+1:0] e;
                check("in_ready_rule", 64'(in_ready_o), 64'(!out_valid_o || out_ready_i));
                if (stall_prev) begin
                    check("hold_valid", 64'(out_valid_o), 64'd1);
                    check("hold_result", 64'(result_o), 64'(prev_res));
                    check("hold_ovf", 64'(overflow_o), 64'(prev_ovf));
                end
                if (out_valid_o && out_ready_i) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", 64'(out_valid_o), 64'd0);
                    end else begin
                        e = exp_q.pop_front();
                        check("stream_result", 64'(result_o), 64'(e[WIDTH:0]));
                        check("stream_ovf", 64'(overflow_o), 64'(e[WIDTH+1]));
                        n_out++;
                    end
                end
                if (in_valid_i && in_ready_o)
                    exp_q.push_back(model(add1_i, add2_i, carry_i, sub_i));
                stall_prev = out_valid_o && !out_ready_i;
                prev_res   = result_o;
                prev_ovf   = overflow_o;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic v, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic c, input logic s);
        in_valid_i = v;
        add1_i     = a;
        add2_i     = b;
        carry_i    = c;
        sub_i      = s;
    endtask

    task automatic run_single(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                              input logic c, input logic s, input logic [63:0] exp_res, input logic exp_ovf);
        int lat;
        logic [WIDTH+1:0] m;
        m = model(a, b, c, s);
        check({name, "_model"}, 64'(m), {30'd0, exp_ovf, exp_res[WIDTH:0]});
        out_ready_i = 1'b1;
        step();
        set_in(1'b1, a, b, c, s);
        step();
        in_valid_i = 1'b0;
        lat = 1;
        while (!out_valid_o && lat < 20) begin
            step();
            lat++;
        end
        check({name, "_latency"}, 64'(lat), 64'(STAGES));
        check({name, "_result"}, 64'(result_o), exp_res);
        check({name, "_ovf"}, 64'(overflow_o), 64'(exp_ovf));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WIDTH-1:0] sa [4];
        logic [WIDTH-1:0] sb [4];
        logic             ss [4];
        int n_before;

        rst_ni      = 1'b0;
        out_ready_i = 1'b1;
        set_in(1'b0, '0, '0, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 64'(out_valid_o), 64'd0);
        check("reset_in_ready", 64'(in_ready_o), 64'd1);
        check("reset_result", 64'(result_o), 64'd0);
        check("reset_ovf", 64'(overflow_o), 64'd0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        mon_en = 1'b1;

        run_single("add_wrap",        32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 64'h1_0000_0000, 1'b0);
        run_single("sub_borrow",      32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, 64'h0_FFFF_FFFE, 1'b0);
        run_single("sub_ovf",         32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 64'h1_7FFF_FFFF, 1'b1);
        run_single("add_ovf",         32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 64'h0_8000_0000, 1'b1);
        run_single("add_neg_ovf",     32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 64'h1_0000_0000, 1'b1);
        run_single("add_cin",         32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, 64'h0_2345_678A, 1'b0);
        run_single("sub_cin_ignored", 32'h0000_000A, 32'h0000_0003, 1'b1, 1'b1, 64'h1_0000_0007, 1'b0);
        run_single("sub_equal",       32'h0000_1234, 32'h0000_1234, 1'b0, 1'b1, 64'h1_0000_0000, 1'b0);
        run_single("seg_carry",       32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 64'h0_0100_0000, 1'b0);

        // Four back-to-back beats; downstream stalls in cycles 5..7.
        sa[0] = 32'hFFFF_FFFF; sb[0] = 32'h0000_0001; ss[0] = 1'b0;
        sa[1] = 32'h7FFF_FFFF; sb[1] = 32'h0000_0001; ss[1] = 1'b0;
        sa[2] = 32'h0000_00FF; sb[2] = 32'h0000_0001; ss[2] = 1'b1;
        sa[3] = 32'h8000_0000; sb[3] = 32'h8000_0000; ss[3] = 1'b1;
        step();
        n_before = n_out;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (cyc < 4) set_in(1'b1, sa[cyc], sb[cyc], 1'b0, ss[cyc]);
            else in_valid_i = 1'b0;
            out_ready_i = !(cyc >= 5 && cyc <= 7);
            #1;
            if (cyc >= 5 && cyc <= 7) check("stall_in_ready", 64'(in_ready_o), 64'd0);
            step();
        end
        check("stream_count", 64'(n_out - n_before), 64'd4);

        // Reset while three beats are in flight.
        out_ready_i = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            set_in(1'b1, 32'h1000_0000 * cyc + 32'h55, 32'h0000_0100, 1'b0, 1'b0);
            step();
        end
        in_valid_i = 1'b0;
        rst_ni     = 1'b0;
        step();
        rst_ni = 1'b1;
        check("midreset_out_valid", 64'(out_valid_o), 64'd0);
        check("midreset_in_ready", 64'(in_ready_o), 64'd1);
        check("midreset_result", 64'(result_o), 64'd0);
        for (int cyc = 0; cyc < 8; cyc++) begin
            step();
            check("midreset_no_stale", 64'(out_valid_o), 64'd0);
        end

        // Mixed traffic with irregular valid/ready.
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic [WIDTH-1:0] ra, rb;
            ra = (cyc % 7 == 0) ? 32'h8000_0000 : $urandom();
            rb = (cyc % 5 == 0) ? 32'hFFFF_FFFF : $urandom();
            set_in($urandom_range(0, 3) != 0, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            out_ready_i = $urandom_range(0, 3) != 0;
            step();
        end
        in_valid_i  = 1'b0;
        out_ready_i = 1'b1;
        repeat (12) step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
